// File: rtl/fu_result_hold.sv
// Per-FU 2-deep result FIFOs that hold completed results until the two-way
// result selector grants them onto the registered CDB broadcast slots.
module fu_result_hold #(
    parameter int FU_SIZE = 20,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 6
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            squash,
    input  logic [FU_SIZE-1:0]              fu_done,
    input  logic [FU_SIZE-1:0][DATA_W-1:0]  fu_value,
    input  logic [FU_SIZE-1:0][TAG_W-1:0]   fu_tag,
    input  logic [4:0]                      fu_num_0,
    input  logic [4:0]                      fu_num_1,
    input  logic [3:0]                      cat_select_0,
    input  logic [3:0]                      cat_select_1,
    output logic [FU_SIZE-1:0]              fu_result_valid,
    output logic [FU_SIZE-1:0]              fu_ready,
    output logic                            cdb_valid_0,
    output logic                            cdb_valid_1,
    output logic [TAG_W-1:0]                cdb_tag_0,
    output logic [TAG_W-1:0]                cdb_tag_1,
    output logic [DATA_W-1:0]               cdb_value_0,
    output logic [DATA_W-1:0]               cdb_value_1,
    output logic                            overflow_err
);

    // Selector indices are 5 bits wide, so FU_SIZE is expected to be at most 32.
    localparam int         IDX_W    = (FU_SIZE > 1) ? $clog2(FU_SIZE) : 1;
    localparam logic [5:0] FU_LIMIT = 6'(FU_SIZE);

    logic [IDX_W-1:0]  idx_0;
    logic [IDX_W-1:0]  idx_1;
    logic              grant_0;
    logic              grant_1;
    logic [TAG_W-1:0]  head_tag   [FU_SIZE];
    logic [DATA_W-1:0] head_value [FU_SIZE];

    logic              cdb_valid_0_reg;
    logic              cdb_valid_1_reg;
    logic [TAG_W-1:0]  cdb_tag_0_reg;
    logic [TAG_W-1:0]  cdb_tag_1_reg;
    logic [DATA_W-1:0] cdb_value_0_reg;
    logic [DATA_W-1:0] cdb_value_1_reg;
    logic              overflow_reg;

    assign idx_0 = fu_num_0[IDX_W-1:0];
    assign idx_1 = fu_num_1[IDX_W-1:0];

    // A grant only counts when a category was selected, the index names a real
    // FU and that FU holds a result; slot 1 yields when both name the same FU.
    assign grant_0 = (cat_select_0 != 4'd0) && ({1'b0, fu_num_0} < FU_LIMIT)
                     && fu_result_valid[idx_0];
    assign grant_1 = (cat_select_1 != 4'd0) && ({1'b0, fu_num_1} < FU_LIMIT)
                     && fu_result_valid[idx_1]
                     && !(grant_0 && (fu_num_1 == fu_num_0));

    genvar gi;
    generate
        for (gi = 0; gi < FU_SIZE; gi++) begin : g_fu
            localparam logic [IDX_W-1:0] GI_IDX = IDX_W'(gi);

            logic [1:0]        count_reg;
            logic [1:0]        count_next;
            logic              head_reg;
            logic              tail_reg;
            logic              push;
            logic              pop;
            logic [TAG_W-1:0]  tag_mem   [2];
            logic [DATA_W-1:0] value_mem [2];

            assign push = fu_done[gi] && (count_reg < 2'd2);
            assign pop  = (grant_0 && (idx_0 == GI_IDX)) || (grant_1 && (idx_1 == GI_IDX));

            always_comb begin
                count_next = count_reg;
                if (push && !pop) begin
                    count_next = count_reg + 2'd1;
                end else if (pop && !push) begin
                    count_next = count_reg - 2'd1;
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    count_reg <= 2'd0;
                    head_reg  <= 1'b0;
                    tail_reg  <= 1'b0;
                end else if (squash) begin
                    count_reg <= 2'd0;
                    head_reg  <= 1'b0;
                    tail_reg  <= 1'b0;
                end else begin
                    count_reg <= count_next;
                    if (push) tail_reg <= ~tail_reg;
                    if (pop)  head_reg <= ~head_reg;
                end
            end

            // Entry storage needs no reset: count gates every read.
            always_ff @(posedge clock) begin
                if (push) begin
                    tag_mem[tail_reg]   <= fu_tag[gi];
                    value_mem[tail_reg] <= fu_value[gi];
                end
            end

            assign fu_result_valid[gi] = (count_reg != 2'd0);
            assign fu_ready[gi]        = (count_reg < 2'd2);
            assign head_tag[gi]        = tag_mem[head_reg];
            assign head_value[gi]      = value_mem[head_reg];
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cdb_valid_0_reg <= 1'b0;
            cdb_valid_1_reg <= 1'b0;
            cdb_tag_0_reg   <= '0;
            cdb_tag_1_reg   <= '0;
            cdb_value_0_reg <= '0;
            cdb_value_1_reg <= '0;
            overflow_reg    <= 1'b0;
        end else begin
            cdb_valid_0_reg <= grant_0 && !squash;
            cdb_valid_1_reg <= grant_1 && !squash;
            // Tag/value hold their last broadcast when the slot is idle.
            if (grant_0 && !squash) begin
                cdb_tag_0_reg   <= head_tag[idx_0];
                cdb_value_0_reg <= head_value[idx_0];
            end
            if (grant_1 && !squash) begin
                cdb_tag_1_reg   <= head_tag[idx_1];
                cdb_value_1_reg <= head_value[idx_1];
            end
            if (|(fu_done & ~fu_ready)) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign cdb_valid_0  = cdb_valid_0_reg;
    assign cdb_valid_1  = cdb_valid_1_reg;
    assign cdb_tag_0    = cdb_tag_0_reg;
    assign cdb_tag_1    = cdb_tag_1_reg;
    assign cdb_value_0  = cdb_value_0_reg;
    assign cdb_value_1  = cdb_value_1_reg;
    assign overflow_err = overflow_reg;

endmodule

// File: tb/tb_fu_result_hold.sv
// Directed bench for fu_result_hold: stimulus queues expected CDB broadcasts,
// a negedge monitor pops and compares them against both broadcast slots.
module tb_fu_result_hold;

    localparam int FU_SIZE = 20;
    localparam int DATA_W  = 32;
    localparam int TAG_W   = 6;

    typedef struct {
        int                cyc;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } exp_t;

    logic                           clock = 1'b0;
    logic                           reset;
    logic                           squash;
    logic [FU_SIZE-1:0]             fu_done;
    logic [FU_SIZE-1:0][DATA_W-1:0] fu_value;
    logic [FU_SIZE-1:0][TAG_W-1:0]  fu_tag;
    logic [4:0]                     fu_num_0;
    logic [4:0]                     fu_num_1;
    logic [3:0]                     cat_select_0;
    logic [3:0]                     cat_select_1;
    logic [FU_SIZE-1:0]             fu_result_valid;
    logic [FU_SIZE-1:0]             fu_ready;
    logic                           cdb_valid_0;
    logic                           cdb_valid_1;
    logic [TAG_W-1:0]               cdb_tag_0;
    logic [TAG_W-1:0]               cdb_tag_1;
    logic [DATA_W-1:0]              cdb_value_0;
    logic [DATA_W-1:0]              cdb_value_1;
    logic                           overflow_err;

    exp_t              q0[$];
    exp_t              q1[$];
    int                cyc = 0;
    int                n_checks = 0;
    int                n_fail = 0;
    logic [TAG_W-1:0]  last_tag0 = '0;
    logic [TAG_W-1:0]  last_tag1 = '0;
    logic [DATA_W-1:0] last_val0 = '0;
    logic [DATA_W-1:0] last_val1 = '0;

    localparam logic [FU_SIZE-1:0] ALL_ONES = {FU_SIZE{1'b1}};

    fu_result_hold #(.FU_SIZE(FU_SIZE), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .fu_done(fu_done), .fu_value(fu_value), .fu_tag(fu_tag),
        .fu_num_0(fu_num_0), .fu_num_1(fu_num_1),
        .cat_select_0(cat_select_0), .cat_select_1(cat_select_1),
        .fu_result_valid(fu_result_valid), .fu_ready(fu_ready),
        .cdb_valid_0(cdb_valid_0), .cdb_valid_1(cdb_valid_1),
        .cdb_tag_0(cdb_tag_0), .cdb_tag_1(cdb_tag_1),
        .cdb_value_0(cdb_value_0), .cdb_value_1(cdb_value_1),
        .overflow_err(overflow_err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Reset clears the broadcast registers, so the idle-hold model restarts at 0.
    always @(posedge reset) begin
        last_tag0 = '0; last_val0 = '0;
        last_tag1 = '0; last_val1 = '0;
    end

    always @(negedge clock) begin
        exp_t e;
        n_checks++;
        if (q0.size() > 0 && q0[0].cyc == cyc) begin
            e = q0.pop_front();
            $display("slot0 cyc=%0d valid=%0b tag=%0h value=%0h (exp tag=%0h value=%0h)",
                     cyc, cdb_valid_0, cdb_tag_0, cdb_value_0, e.tag, e.val);
            if (cdb_valid_0 !== 1'b1 || cdb_tag_0 !== e.tag || cdb_value_0 !== e.val) begin
                n_fail++;
                $display("FAIL bcast0 cyc=%0d: got v=%0b t=%0h d=%0h, expected v=1 t=%0h d=%0h",
                         cyc, cdb_valid_0, cdb_tag_0, cdb_value_0, e.tag, e.val);
            end
            last_tag0 = e.tag; last_val0 = e.val;
        end else if (cdb_valid_0 !== 1'b0 || cdb_tag_0 !== last_tag0 || cdb_value_0 !== last_val0) begin
            n_fail++;
            $display("FAIL idle0 cyc=%0d: got v=%0b t=%0h d=%0h, expected v=0 t=%0h d=%0h",
                     cyc, cdb_valid_0, cdb_tag_0, cdb_value_0, last_tag0, last_val0);
        end
        n_checks++;
        if (q1.size() > 0 && q1[0].cyc == cyc) begin
            e = q1.pop_front();
            $display("slot1 cyc=%0d valid=%0b tag=%0h value=%0h (exp tag=%0h value=%0h)",
                     cyc, cdb_valid_1, cdb_tag_1, cdb_value_1, e.tag, e.val);
            if (cdb_valid_1 !== 1'b1 || cdb_tag_1 !== e.tag || cdb_value_1 !== e.val) begin
                n_fail++;
                $display("FAIL bcast1 cyc=%0d: got v=%0b t=%0h d=%0h, expected v=1 t=%0h d=%0h",
                         cyc, cdb_valid_1, cdb_tag_1, cdb_value_1, e.tag, e.val);
            end
            last_tag1 = e.tag; last_val1 = e.val;
        end else if (cdb_valid_1 !== 1'b0 || cdb_tag_1 !== last_tag1 || cdb_value_1 !== last_val1) begin
            n_fail++;
            $display("FAIL idle1 cyc=%0d: got v=%0b t=%0h d=%0h, expected v=0 t=%0h d=%0h",
                     cyc, cdb_valid_1, cdb_tag_1, cdb_value_1, last_tag1, last_val1);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("check %s = %0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        squash = 1'b0;
        fu_done = '0;
        fu_value = '0;
        fu_tag = '0;
        fu_num_0 = '0;
        fu_num_1 = '0;
        cat_select_0 = '0;
        cat_select_1 = '0;
    endtask

    task automatic done(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
        fu_done[i] = 1'b1;
        fu_tag[i] = t;
        fu_value[i] = v;
    endtask

    task automatic grant(input int slot, input logic [4:0] n, input logic [3:0] cat);
        if (slot == 0) begin
            fu_num_0 = n; cat_select_0 = cat;
        end else begin
            fu_num_1 = n; cat_select_1 = cat;
        end
    endtask

    // Expected broadcast appears after the coming edge.
    task automatic expect_bc(input int slot, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
        exp_t e;
        e.cyc = cyc + 1; e.tag = t; e.val = v;
        if (slot == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        #2;
        check("reset_valid", 64'(fu_result_valid), 64'd0);
        check("reset_ready", 64'(fu_ready), 64'(ALL_ONES));
        check("reset_overflow", 64'(overflow_err), 64'd0);
        check("reset_cdb_tag0", 64'(cdb_tag_0), 64'd0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // Single result: push, then grant one cycle later.
        done(4, 6'h05, 32'h0000_00AB);
        tick(); clear_inputs();
        check("s1_valid4_after_push", 64'(fu_result_valid[4]), 64'd1);
        grant(0, 5'd4, 4'b0001); expect_bc(0, 6'h05, 32'h0000_00AB);
        tick(); clear_inputs();
        check("s1_valid4_after_pop", 64'(fu_result_valid[4]), 64'd0);

        // Three results into FU 13: third is dropped.
        done(13, 6'h11, 32'h1111_0001);
        tick(); clear_inputs();
        check("s2_ready13_one", 64'(fu_ready[13]), 64'd1);
        done(13, 6'h12, 32'h1111_0002);
        tick(); clear_inputs();
        check("s2_ready13_full", 64'(fu_ready[13]), 64'd0);
        check("s2_overflow_before", 64'(overflow_err), 64'd0);
        done(13, 6'h13, 32'h1111_0003);
        tick(); clear_inputs();
        check("s2_overflow_after", 64'(overflow_err), 64'd1);
        grant(1, 5'd13, 4'b0010); expect_bc(1, 6'h11, 32'h1111_0001);
        tick();
        expect_bc(1, 6'h12, 32'h1111_0002);
        tick(); clear_inputs();
        tick();
        check("s2_valid13_drained", 64'(fu_result_valid[13]), 64'd0);

        // Simultaneous push and pop at count 1.
        done(9, 6'h21, 32'hA000_0021);
        tick(); clear_inputs();
        done(9, 6'h22, 32'hB000_0022);
        grant(0, 5'd9, 4'b0100); expect_bc(0, 6'h21, 32'hA000_0021);
        tick(); clear_inputs();
        check("s3_valid9", 64'(fu_result_valid[9]), 64'd1);
        check("s3_ready9", 64'(fu_ready[9]), 64'd1);
        grant(0, 5'd9, 4'b1000); expect_bc(0, 6'h22, 32'hB000_0022);
        tick(); clear_inputs();
        check("s3_valid9_empty", 64'(fu_result_valid[9]), 64'd0);

        // Ungranted default index and out-of-range index are ignored.
        grant(0, 5'd0, 4'b0000);
        grant(1, 5'd25, 4'b0100);
        tick(); clear_inputs();
        check("s4_no_state_change", 64'(fu_result_valid), 64'd0);

        // Two different FUs at once, then both slots on the same FU.
        done(5, 6'h31, 32'h0000_3131);
        done(6, 6'h32, 32'h0000_3232);
        done(7, 6'h33, 32'h0000_3333);
        tick(); clear_inputs();
        grant(0, 5'd5, 4'b0001); expect_bc(0, 6'h31, 32'h0000_3131);
        grant(1, 5'd6, 4'b1000); expect_bc(1, 6'h32, 32'h0000_3232);
        tick(); clear_inputs();
        grant(0, 5'd7, 4'b0001); grant(1, 5'd7, 4'b0010);
        expect_bc(0, 6'h33, 32'h0000_3333);
        tick(); clear_inputs();
        check("s5_all_empty", 64'(fu_result_valid), 64'd0);

        // Squash with FUs 2 and 3 full, grants and a fresh push pending.
        done(2, 6'h41, 32'h4100_0000); done(3, 6'h43, 32'h4300_0000);
        tick(); clear_inputs();
        done(2, 6'h42, 32'h4200_0000); done(3, 6'h44, 32'h4400_0000);
        tick(); clear_inputs();
        check("s6_valid_full", 64'(fu_result_valid), 64'h0000C);
        check("s6_ready_full", 64'(fu_ready[3:2]), 64'd0);
        squash = 1'b1;
        grant(0, 5'd2, 4'b0001); grant(1, 5'd3, 4'b0001);
        done(4, 6'h3F, 32'hDEAD_BEEF);
        tick(); clear_inputs();
        check("s6_squash_valid", 64'(fu_result_valid), 64'd0);
        check("s6_squash_overflow", 64'(overflow_err), 64'd1);
        done(2, 6'h51, 32'h5100_0051);
        tick(); clear_inputs();
        grant(0, 5'd2, 4'b0001); expect_bc(0, 6'h51, 32'h5100_0051);
        tick(); clear_inputs();

        // Asynchronous reset between edges while data is held.
        done(1, 6'h01, 32'h6100_0001); done(10, 6'h0A, 32'h6A00_000A);
        tick(); clear_inputs();
        grant(0, 5'd1, 4'b0001); expect_bc(0, 6'h01, 32'h6100_0001);
        tick(); clear_inputs();
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("s7_reset_valid", 64'(fu_result_valid), 64'd0);
        check("s7_reset_ready", 64'(fu_ready), 64'(ALL_ONES));
        check("s7_reset_cdb_valid0", 64'(cdb_valid_0), 64'd0);
        check("s7_reset_cdb_value0", 64'(cdb_value_0), 64'd0);
        check("s7_reset_overflow", 64'(overflow_err), 64'd0);
        grant(1, 5'd10, 4'b0001);
        tick();
        reset = 1'b0;
        tick(); clear_inputs();
        check("s7_release_ready", 64'(fu_ready), 64'(ALL_ONES));
        check("s7_release_valid", 64'(fu_result_valid), 64'd0);
        tick(); tick(); tick();

        check("queues_drained", 64'(q0.size() + q1.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fu_result_hold.md
FU_RESULT_HOLD -- requirements
Module: fu_result_hold

Interface
REQ-001 The module SHALL have parameter FU_SIZE, default 20, the number of functional units.
REQ-002 The module SHALL have parameter DATA_W, default 32, the result value width.
REQ-003 The module SHALL have parameter TAG_W, default 6, the destination tag width.
REQ-004 The module SHALL have port clock, input, 1, the single clock, with all state on its rising edge.
REQ-005 The module SHALL have port reset, input, 1, the reset, which is asynchronous and active-high.
REQ-006 The module SHALL have port squash, input, 1, a mispredict flush.
REQ-007 The module SHALL have port fu_done, input, FU_SIZE, per-FU result-produced strobes.
REQ-008 The module SHALL have port fu_value, input, FU_SIZE x DATA_W, the per-FU result values.
REQ-009 The module SHALL have port fu_tag, input, FU_SIZE x TAG_W, the per-FU destination tags.
REQ-010 The module SHALL have port fu_num_0, input, 5, the slot-0 grant index from the two-way result selector.
REQ-011 The module SHALL have port fu_num_1, input, 5, the slot-1 grant index from that selector.
REQ-012 The module SHALL have port cat_select_0, input, 4, the slot-0 one-hot category grant; nonzero qualifies fu_num_0.
REQ-013 The module SHALL have port cat_select_1, input, 4, the slot-1 one-hot category grant; nonzero qualifies fu_num_1.
REQ-014 The module SHALL have port fu_result_valid, output, FU_SIZE, per-FU "result pending", which feeds the selector.
REQ-015 The module SHALL have port fu_ready, output, FU_SIZE, per-FU "may issue fu_done this cycle".
REQ-016 The module SHALL have ports cdb_valid_0 and cdb_valid_1, output, 1 each, the registered broadcast valids.
REQ-017 The module SHALL have ports cdb_tag_0 and cdb_tag_1, output, TAG_W each, the broadcast tags.
REQ-018 The module SHALL have ports cdb_value_0 and cdb_value_1, output, DATA_W each, the broadcast values.
REQ-019 The module SHALL have port overflow_err, output, 1, a sticky dropped-result flag.

Function
REQ-020 Each FU SHALL own a 2-entry FIFO of {tag, value} with a 2-bit count, a head pointer and a tail pointer.
REQ-021 fu_result_valid[i] SHALL equal (count[i] != 0), decoded from registered state only, with no input-to-output combinational path.
REQ-022 fu_ready[i] SHALL equal (count[i] < 2), taken from the registered count, with no bypass from a same-cycle pop.
REQ-023 A push SHALL occur when fu_done[i] && fu_ready[i], writing fu_tag[i] and fu_value[i] at the tail; the entry becomes visible on fu_result_valid the next cycle, with no same-cycle bypass.
REQ-024 fu_done[i] while fu_ready[i]==0 SHALL be dropped and SHALL set overflow_err, which holds until reset.
REQ-025 Slot k grant SHALL be valid iff cat_select_k != 0, fu_num_k < FU_SIZE, and fu_result_valid[fu_num_k]==1; otherwise the grant SHALL be ignored, including the selector's default index when no category is granted.
REQ-026 A valid slot-k grant SHALL pop the head of FIFO fu_num_k at the clock edge.
REQ-027 At that same edge, the popped entry SHALL be registered into cdb_valid_k=1, cdb_tag_k and cdb_value_k, giving grant-to-broadcast latency of exactly 1 cycle.
REQ-028 When slot k has no valid grant, cdb_valid_k SHALL be 0 the next cycle, and cdb_tag_k/cdb_value_k SHALL hold their previous values.
REQ-029 If both slots grant the same FU index, it SHALL pop once: cdb_valid_0=1 and cdb_valid_1=0.
REQ-030 Push and pop on the same FU in the same cycle SHALL leave count unchanged and update both pointers; this applies only to count 1, since count 2 blocks the push.
REQ-031 Pointers SHALL wrap modulo 2, and FIFO order SHALL be strictly preserved per FU.
REQ-032 Count SHALL never exceed 2 or go below 0.
REQ-033 squash SHALL clear all counts and pointers and force cdb_valid_0/1 to 0 at the next edge.
REQ-034 squash SHALL take priority over same-cycle pushes and pops, and squash SHALL NOT clear overflow_err.

Reset
REQ-035 Reset assertion SHALL immediately, without waiting for a clock edge, clear all counts, pointers, cdb_valid_0/1, cdb_tag_0/1, cdb_value_0/1 and overflow_err to 0.
REQ-036 Consequently, during reset fu_result_valid SHALL be all 0 and fu_ready SHALL be all 1.
REQ-037 Reset asserted mid-operation SHALL discard all held results, and no broadcast SHALL occur in the first cycle after release.

Verification
REQ-038 Scenario: fu_done[4] with tag 0x05 and value 0xAB, then slot-0 grant fu_num_0=4, cat_select_0=4'b0001 the next cycle -> fu_result_valid[4]=1 in cycle 1; cdb_valid_0=1, cdb_tag_0=0x05, cdb_value_0=0xAB in cycle 2; fu_result_valid[4]=0.
REQ-039 Scenario: three consecutive fu_done[13] with no grants -> fu_ready[13]=0 after the second push; third result dropped; overflow_err=1; two later grants broadcast the first two values in order.
REQ-040 Scenario: FU 9 at count 1 with simultaneous fu_done[9] and grant -> count stays 1; old head broadcast; new value broadcast after the next grant.
REQ-041 Scenario: fu_num_0=0 with cat_select_0=0 and FU 0 empty -> cdb_valid_0=0; no state change.
REQ-042 Scenario: FUs 2 and 3 both full plus squash asserted with grants -> all fu_result_valid=0 and cdb_valid_0/1=0 next cycle; overflow_err unchanged.
REQ-043 Scenario: reset asserted between clock edges with FIFOs holding data -> outputs clear immediately; after release, fu_ready is all 1s.
